barrel_shifter: RTL and testbench
=================================

# barrel_shifter

Registered dual-direction barrel rotator. Each cycle it rotates one WIDTH-bit input word by a shift amount `rt`, producing both the rotate-right and rotate-left results. It uses a log2(WIDTH)-stage mux network followed by one output register. It sits in datapath blocks needing constant-latency variable rotation. The module is instantiated as `barrel_shift`.

## Interface
Parameters:
- `WIDTH`, default 16: data width. Must be a power of two and ≥ 2.
- `SHW`, default $clog2(WIDTH): shift-amount width. Derived; not to be overridden.

Ports:
- `clk`  in  1: sole clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `in`  in  WIDTH: data word to rotate.
- `rt`  in  SHW: rotate amount, unsigned, range 0..WIDTH-1.
- `in_vld`  in  1: qualifies `in`/`rt` this cycle.
- `out_rh`  out  WIDTH: `in` rotated right by `rt`.
- `out_lf`  out  WIDTH: `in` rotated left by `rt`.
- `out_vld`  out  1: `out_rh`/`out_lf` hold a result from a valid input.

## Operation
- Rotate right: `out_rh[i] = in[(i + rt) mod WIDTH]`.
- Rotate left: `out_lf[i] = in[(i - rt) mod WIDTH]`.
- Rotation only, no fill bits: every input bit appears exactly once in each output.
- Network: SHW stages. Stage k rotates by 2^k when `rt[k]` = 1, otherwise passes through.
  - Right and left networks are independent instances.
  - Left may alternatively be computed as right-rotate by (WIDTH − rt) mod WIDTH; the result must be identical.
- `rt` = 0: both outputs equal `in`.
- `rt` spans the full range by construction, so no out-of-range case exists.
- `in_vld` = 0: output registers hold their previous values; `out_vld` deasserts the following cycle.
- No internal state other than the output registers and `out_vld`.

## Timing
- Latency is exactly 1 cycle. Inputs are sampled at rising edge N; results are visible after edge N and remain stable until edge N+1.
- Throughput is one word per cycle; back-to-back valid inputs are allowed with no bubbles.
- Reset values: `out_rh` = 0, `out_lf` = 0, `out_vld` = 0.
  - Asserting `rst` clears the outputs immediately, regardless of `clk`.
  - A result in flight when reset hits mid-operation is discarded.
- First valid result after reset release: the input sampled on the first rising edge with `rst` low and `in_vld` high.
- Combinational path from the input flops to the output register is SHW levels of 2:1 mux.

## Structure
- Shared package `barrel_pkg` holds:
  - `localparam` default `BS_WIDTH` = 16;
  - a typedef for the data word;
  - a function `rotr(word, amt)` as the reference model for benches.
- One natural sub-module, `barrel_rot_net`:
  - purely combinational;
  - parameters WIDTH and DIR (0 = right, 1 = left);
  - contains the SHW-stage mux chain;
  - instantiated twice in the top.
- The top holds only the output registers, `out_vld` and the reset logic.

## Test plan
- WIDTH = 16, `in` = 0xF04F, `rt` = 5, `in_vld` = 1 → one cycle later `out_rh` = 0x7F82, `out_lf` = 0x09FE, `out_vld` = 1.
- `rt` = 0 with `in` = 0xA5C3 → `out_rh` = `out_lf` = 0xA5C3.
- `in` = 0x0001, sweeping `rt` 0..15 back-to-back → `out_lf` = 1 << rt and `out_rh` = 1 << ((16 − rt) mod 16), each one cycle after its input, no gaps.
- `rt` = 15, `in` = 0x8001 → `out_rh` = 0x0003, `out_lf` = 0xC000.
- Assert `rst` asynchronously between clock edges while outputs are non-zero → all outputs go to 0 immediately. After release with `in_vld` = 0, outputs stay at 0.
- Random regression: 10k random (`in`, `rt`) pairs checked against `barrel_pkg::rotr`, including the identity `out_lf` = rotr(`in`, (16 − rt) mod 16).

Source files
------------

// File: rtl/barrel_pkg.sv
// Shared types and reference rotate function for the barrel rotator.
package barrel_pkg;

  localparam int unsigned BS_WIDTH = 16;
  localparam int unsigned BS_SHW   = $clog2(BS_WIDTH);

  typedef logic [BS_WIDTH-1:0] word_t;

  // Reference rotate-right: result[i] = word[(i + amt) mod BS_WIDTH]
  function automatic word_t rotr(input word_t word, input int unsigned amt);
    word_t r;
    r = '0;
    for (int unsigned i = 0; i < BS_WIDTH; i++) begin
      r[BS_SHW'(i)] = word[BS_SHW'((i + amt) % BS_WIDTH)];
    end
    return r;
  endfunction

endpackage

// File: rtl/barrel_rot_net.sv
// Combinational log2(WIDTH)-stage rotate network; DIR 0 rotates right, 1 rotates left.
module barrel_rot_net #(
  parameter int unsigned WIDTH = 16,
  parameter bit          DIR   = 1'b0
) (
  input  logic [WIDTH-1:0]         in_word,
  input  logic [$clog2(WIDTH)-1:0] amt,
  output logic [WIDTH-1:0]         out_word_c
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] stg [SHW+1];

  assign stg[0] = in_word;

  // Stage k rotates by 2^k when amt[k] is set
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int unsigned STEP = 1 << k;
    logic [WIDTH-1:0] rot;

    if (DIR == 1'b0) begin : g_right
      assign rot = {stg[k][STEP-1:0], stg[k][WIDTH-1:STEP]};
    end else begin : g_left
      assign rot = {stg[k][WIDTH-STEP-1:0], stg[k][WIDTH-1:WIDTH-STEP]};
    end

    assign stg[k+1] = amt[k] ? rot : stg[k];
  end

  assign out_word_c = stg[SHW];

endmodule

// File: rtl/barrel_shifter.sv
// Registered dual-direction barrel rotator with one cycle of latency.
module barrel_shifter
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = BS_WIDTH,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   rt,
  input  logic             in_vld,
  output logic [WIDTH-1:0] out_rh,
  output logic [WIDTH-1:0] out_lf,
  output logic             out_vld
);

  logic [WIDTH-1:0] rh_c;
  logic [WIDTH-1:0] lf_c;
  logic [WIDTH-1:0] out_rh_d, out_rh_q;
  logic [WIDTH-1:0] out_lf_d, out_lf_q;
  logic             out_vld_d, out_vld_q;

  barrel_rot_net #(.WIDTH(WIDTH), .DIR(1'b0)) u_net_rh (
    .in_word    (in),
    .amt        (rt),
    .out_word_c (rh_c)
  );

  barrel_rot_net #(.WIDTH(WIDTH), .DIR(1'b1)) u_net_lf (
    .in_word    (in),
    .amt        (rt),
    .out_word_c (lf_c)
  );

  // Results only update on a valid input; otherwise the last result is held
  always_comb begin
    out_rh_d  = out_rh_q;
    out_lf_d  = out_lf_q;
    out_vld_d = in_vld;
    if (in_vld) begin
      out_rh_d = rh_c;
      out_lf_d = lf_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_rh_q  <= '0;
      out_lf_q  <= '0;
      out_vld_q <= 1'b0;
    end else begin
      out_rh_q  <= out_rh_d;
      out_lf_q  <= out_lf_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign out_rh  = out_rh_q;
  assign out_lf  = out_lf_q;
  assign out_vld = out_vld_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// Directed and random bench for barrel_shifter with a scoreboard of expected results.
module tb_barrel_shifter;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic [3:0]  rt;
  logic        in_vld;
  logic [15:0] out_rh;
  logic [15:0] out_lf;
  logic        out_vld;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] rh;
    logic [15:0] lf;
    logic        vld;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] last_rh;
  logic [15:0] last_lf;

  barrel_shifter barrel_shift (
    .clk     (clk),
    .rst     (rst),
    .in      (din),
    .rt      (rt),
    .in_vld  (in_vld),
    .out_rh  (out_rh),
    .out_lf  (out_lf),
    .out_vld (out_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] m_rotr(input logic [15:0] x, input logic [3:0] r);
    logic [31:0] d;
    d = {x, x} >> r;
    return d[15:0];
  endfunction

  function automatic logic [15:0] m_rotl(input logic [15:0] x, input logic [3:0] r);
    logic [31:0] d;
    d = {x, x} << r;
    return d[31:16];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one input cycle, queue its expectation, then check the registered result
  task automatic step(input logic [15:0] d, input logic [3:0] r, input logic v);
    exp_t e;
    din    = d;
    rt     = r;
    in_vld = v;
    if (v) begin
      last_rh = m_rotr(d, r);
      last_lf = m_rotl(d, r);
    end
    e.rh  = last_rh;
    e.lf  = last_lf;
    e.vld = v;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      chk("out_rh", out_rh, e.rh);
      chk("out_lf", out_lf, e.lf);
      chk("out_vld", {15'd0, out_vld}, {15'd0, e.vld});
    end
  endtask

  initial begin
    int unsigned a;
    logic [15:0] rd;
    logic [3:0]  rr;

    rst     = 1'b1;
    din     = '0;
    rt      = '0;
    in_vld  = 1'b0;
    last_rh = '0;
    last_lf = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rh", out_rh, 16'h0000);
    chk("rst_lf", out_lf, 16'h0000);
    chk("rst_vld", {15'd0, out_vld}, 16'd0);
    rst = 1'b0;

    step(16'hF04F, 4'd5, 1'b1);
    chk("vec5_rh", out_rh, 16'h7F82);
    chk("vec5_lf", out_lf, 16'h09FE);

    step(16'hFFFF, 4'd7, 1'b0);
    chk("hold_rh", out_rh, 16'h7F82);
    chk("hold_vld", {15'd0, out_vld}, 16'd0);

    step(16'hA5C3, 4'd0, 1'b1);
    chk("rt0_rh", out_rh, 16'hA5C3);
    chk("rt0_lf", out_lf, 16'hA5C3);

    for (int i = 0; i < 16; i++) begin
      step(16'h0001, 4'(i), 1'b1);
      chk("sweep_lf", out_lf, 16'(32'd1 << i));
      chk("sweep_rh", out_rh, 16'(32'd1 << ((16 - i) % 16)));
    end

    step(16'h8001, 4'd15, 1'b1);
    chk("rt15_rh", out_rh, 16'h0003);
    chk("rt15_lf", out_lf, 16'hC000);

    // Async reset mid-cycle with a valid input pending
    din    = 16'h1234;
    rt     = 4'd3;
    in_vld = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_rh", out_rh, 16'h0000);
    chk("arst_lf", out_lf, 16'h0000);
    chk("arst_vld", {15'd0, out_vld}, 16'd0);
    sb.delete();
    last_rh = '0;
    last_lf = '0;
    @(posedge clk);
    #1;
    chk("arst_hold_rh", out_rh, 16'h0000);
    in_vld = 1'b0;
    rst    = 1'b0;
    step(16'hBEEF, 4'd9, 1'b0);
    step(16'hCAFE, 4'd2, 1'b0);
    chk("post_rst_lf", out_lf, 16'h0000);

    for (int i = 0; i < 10000; i++) begin
      rd = 16'($urandom);
      rr = 4'($urandom_range(0, 15));
      step(rd, rr, 1'b1);
      a = (16 - int'(rr)) % 16;
      chk("pkg_rh", out_rh, barrel_pkg::rotr(rd, int'(rr)));
      chk("pkg_ident_lf", out_lf, barrel_pkg::rotr(rd, a));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
